// File: rtl/vga_fb_fetch_ctrl.sv
// Framebuffer fetch sequencer: walks [FBSTART, FBSTART+FBSIZE) as AXI4 INCR read
// bursts, clipped to BRULEN, the frame tail and 4 KB pages, into the pixel FIFO.
module vga_fb_fetch_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_CNT_WIDTH = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic [ADDR_WIDTH-1:0]     fbstart_i,
   input  logic [ADDR_WIDTH-1:0]     fbsize_i,
   input  logic [7:0]                brulen_i,
   input  logic                      frame_start_i,
   input  logic [FIFO_CNT_WIDTH-1:0] fifo_free_i,
   output logic                      fifo_wr_o,
   output logic [DATA_WIDTH-1:0]     fifo_wdata_o,
   output logic [ADDR_WIDTH-1:0]     araddr_o,
   output logic [7:0]                arlen_o,
   output logic                      arvalid_o,
   input  logic                      arready_i,
   input  logic [DATA_WIDTH-1:0]     rdata_i,
   input  logic [1:0]                rresp_i,
   input  logic                      rlast_i,
   input  logic                      rvalid_i,
   output logic                      rready_o,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic                      err_o,
   input  logic                      err_clr_i
);
   localparam int RW = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_SPACE, S_ADDR, S_DATA} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [RW-1:0]         rem_q, rem_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [8:0]            cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] new_addr_w;
   logic [RW-1:0]         new_rem_w;
   logic [8:0]            blen_w, burst_w, burst_m1_w, bcnt_w;
   logic [10:0]           bnd_w;
   logic                  space_ok_w, beat_w, last_w, restart_w, err_set_w;
   logic                  unused_ok_w;

   assign unused_ok_w = ^{fbstart_i[1:0], fbsize_i[1:0]};

   assign new_addr_w = {fbstart_i[ADDR_WIDTH-1:2], 2'b00};
   assign new_rem_w  = fbsize_i[ADDR_WIDTH-1:2];
   assign blen_w     = (brulen_i == 8'd0) ? 9'd1 : {1'b0, brulen_i};
   // Beats left before the next 4 KB page: 1..1024.
   assign bnd_w      = 11'd1024 - {1'b0, addr_q[11:2]};
   assign bcnt_w     = {1'b0, arlen_q} + 9'd1;

   always_comb begin
      burst_w = blen_w;
      if (rem_q < {{(RW-9){1'b0}}, burst_w}) burst_w = rem_q[8:0];
      if ({2'b00, burst_w} > bnd_w) burst_w = bnd_w[8:0];
   end

   assign burst_m1_w = burst_w - 9'd1;
   assign space_ok_w = 32'(fifo_free_i) >= 32'(burst_w);
   assign beat_w     = (state_q == S_DATA) && rvalid_i;
   assign last_w     = beat_w && rlast_i;
   assign restart_w  = pend_q || frame_start_i;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      err_set_w = 1'b0;
      if (frame_start_i && (state_q != S_IDLE)) begin
         err_set_w = 1'b1;
         pend_d    = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (frame_start_i && en_i) begin
               addr_d = new_addr_w;
               rem_d  = new_rem_w;
               if (new_rem_w == '0) done_d = 1'b1;
               else                 state_d = S_WAIT_SPACE;
            end
         end
         S_WAIT_SPACE: begin
            pend_d = 1'b0;
            if (!en_i) begin
               state_d = S_IDLE;
            end else if (frame_start_i) begin
               // No burst outstanding, so a late frame restarts right away.
               addr_d = new_addr_w;
               rem_d  = new_rem_w;
               if (new_rem_w == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (space_ok_w) begin
               araddr_d = addr_q;
               arlen_d  = burst_m1_w[7:0];
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (arready_i) begin
               addr_d  = addr_q + {{(ADDR_WIDTH-11){1'b0}}, bcnt_w, 2'b00};
               rem_d   = rem_q - {{(RW-9){1'b0}}, bcnt_w};
               cnt_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_w) begin
               cnt_d = cnt_q + 9'd1;
               if (rresp_i != 2'b00) err_set_w = 1'b1;
               if (rlast_i) begin
                  if (cnt_q != {1'b0, arlen_q}) err_set_w = 1'b1;
                  if (restart_w) begin
                     pend_d = 1'b0;
                     addr_d = new_addr_w;
                     rem_d  = new_rem_w;
                     if (new_rem_w == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_WAIT_SPACE;
                     end
                  end else if (!en_i || (rem_q == '0)) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_WAIT_SPACE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      err_d = err_q;
      if (err_clr_i) err_d = 1'b0;
      if (err_set_w) err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         araddr_q <= '0;
         rem_q    <= '0;
         arlen_q  <= '0;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         araddr_q <= araddr_d;
         rem_q    <= rem_d;
         arlen_q  <= arlen_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign fifo_wr_o    = beat_w;
   assign fifo_wdata_o = rdata_i;
   assign araddr_o     = araddr_q;
   assign arlen_o      = arlen_q;
   assign arvalid_o    = (state_q == S_ADDR);
   assign rready_o     = (state_q == S_DATA);
   assign busy_o       = (state_q != S_IDLE);
   assign err_o        = err_q;
   // Zero-size frames report one cycle after the start; real frames with the last push.
   assign frame_done_o = done_q || (last_w && !restart_w && en_i && (rem_q == '0));

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Bench for vga_fb_fetch_ctrl: an AXI read slave plus a whole-frame burst/pixel
// model built up front from the configuration, checked beat by beat.
module tb_vga_fb_fetch_ctrl;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int FW = 10;

   logic          clk = 1'b0;
   logic          rst_i, en_i, frame_start_i, arready_i, rlast_i, rvalid_i, err_clr_i;
   logic [AW-1:0] fbstart_i, fbsize_i;
   logic [7:0]    brulen_i;
   logic [FW-1:0] fifo_free_i;
   logic [DW-1:0] rdata_i;
   logic [1:0]    rresp_i;
   logic          fifo_wr_o, arvalid_o, rready_o, busy_o, frame_done_o, err_o;
   logic [DW-1:0] fifo_wdata_o;
   logic [AW-1:0] araddr_o;
   logic [7:0]    arlen_o;

   always #5 clk = ~clk;

   vga_fb_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_CNT_WIDTH(FW)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .fbstart_i(fbstart_i), .fbsize_i(fbsize_i),
      .brulen_i(brulen_i), .frame_start_i(frame_start_i), .fifo_free_i(fifo_free_i),
      .fifo_wr_o(fifo_wr_o), .fifo_wdata_o(fifo_wdata_o), .araddr_o(araddr_o),
      .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i), .rdata_i(rdata_i),
      .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o), .err_clr_i(err_clr_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus controls, applied on the falling edge by step().
   bit            rst_v = 1'b0, en_v = 1'b1, clr_v = 1'b0, bad_resp_v = 1'b0;
   bit            hs_rand = 1'b0, free_rand = 1'b0, ar_block = 1'b0;
   logic [FW-1:0] free_fixed = 10'd512;

   // AXI slave state and the reference model.
   int          sl_left = 0;
   logic [31:0] sl_addr = '0;
   logic [31:0] exp_q[$];
   logic [31:0] eb_addr_q[$];
   logic [7:0]  eb_len_q[$];
   bit          err_m = 1'b0, zero_arm = 1'b0;
   bit          prev_arvalid = 1'b0, prev_arready = 1'b0;
   logic [31:0] prev_araddr = '0;
   logic [7:0]  prev_arlen = '0;
   logic [FW-1:0] prev_free = '0;
   int          done_cnt = 0, push_cnt = 0, cur_words = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Whole-frame plan: every burst and every pixel word, appended to the queues.
   task automatic build_frame(input logic [31:0] s, input logic [31:0] sz, input logic [7:0] bl);
      logic [31:0] a;
      int unsigned r, b, lim;
      a = {s[31:2], 2'b00};
      r = sz >> 2;
      while (r > 0) begin
         b   = (bl == 0) ? 1 : bl;
         if (r < b) b = r;
         lim = (4096 - a[11:0]) / 4;
         if (lim < b) b = lim;
         eb_addr_q.push_back(a);
         eb_len_q.push_back(8'(b - 1));
         for (int k = 0; k < int'(b); k++) exp_q.push_back(word_of(a + 32'(4 * k)));
         a = a + 32'(4 * b);
         r = r - b;
      end
   endtask

   task automatic step(input bit fs);
      logic push, exp_done;
      int   need;
      @(negedge clk);
      rst_i         = rst_v;
      en_i          = en_v;
      err_clr_i     = clr_v;
      frame_start_i = fs;
      arready_i     = ar_block ? 1'b0 : (hs_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      fifo_free_i   = free_rand ? FW'($urandom_range(0, 300)) : free_fixed;
      if (sl_left > 0) begin
         rvalid_i = hs_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         rlast_i  = (sl_left == 1);
         rdata_i  = word_of(sl_addr);
         rresp_i  = bad_resp_v ? 2'b10 : 2'b00;
      end else begin
         rvalid_i = 1'b0;
         rlast_i  = 1'b0;
         rresp_i  = 2'b00;
         rdata_i  = $urandom;
      end
      #1;
      if (prev_arvalid && !prev_arready) begin
         check("ar_hold_valid", arvalid_o, 1);
         check("ar_hold_addr", araddr_o, prev_araddr);
         check("ar_hold_len", arlen_o, prev_arlen);
      end
      if (arvalid_o && !prev_arvalid && eb_len_q.size() > 0) begin
         need = int'(eb_len_q[0]) + 1;
         check("ar_fifo_space", (int'(prev_free) >= need) ? 1 : 0, 1);
      end
      if (sl_left > 0) check("rready", rready_o, 1);
      push = rvalid_i && rready_o;
      check("fifo_wr", fifo_wr_o, push);
      if (push) begin
         check("fifo_wdata_pass", fifo_wdata_o, rdata_i);
         check("push_expected", (exp_q.size() != 0) ? 1 : 0, 1);
         if (exp_q.size() != 0) check("pixel", fifo_wdata_o, exp_q.pop_front());
         push_cnt++;
         sl_addr = sl_addr + 4;
         sl_left--;
      end
      if (arvalid_o && arready_i) begin
         check("ar_expected", (eb_addr_q.size() != 0) ? 1 : 0, 1);
         if (eb_addr_q.size() != 0) begin
            check("araddr", araddr_o, eb_addr_q.pop_front());
            check("arlen", arlen_o, eb_len_q.pop_front());
         end
         sl_addr = araddr_o;
         sl_left = int'(arlen_o) + 1;
      end
      exp_done = (push && rlast_i && en_v && exp_q.size() == 0 && eb_addr_q.size() == 0) || zero_arm;
      check("frame_done", frame_done_o, exp_done);
      if (frame_done_o) done_cnt++;
      check("err", err_o, err_m);
      if (clr_v) err_m = 1'b0;
      if (push && rresp_i != 2'b00) err_m = 1'b1;
      zero_arm     = fs && (cur_words == 0) && !rst_v;
      prev_arvalid = arvalid_o && !rst_v;
      prev_arready = arready_i;
      prev_araddr  = araddr_o;
      prev_arlen   = arlen_o;
      prev_free    = fifo_free_i;
      if (rst_v) begin
         err_m   = 1'b0;
         sl_left = 0;
      end
   endtask

   task automatic start_frame(input logic [31:0] s, input logic [31:0] sz, input logic [7:0] bl);
      fbstart_i = s;
      fbsize_i  = sz;
      brulen_i  = bl;
      build_frame(s, sz, bl);
      cur_words = int'(sz >> 2);
      push_cnt  = 0;
      done_cnt  = 0;
      step(1'b1);
   endtask

   task automatic finish_frame(input int exp_pushes);
      int budget;
      budget = 0;
      while (done_cnt == 0 && budget < 20000) begin
         step(1'b0);
         budget++;
      end
      check("frame_done_count", done_cnt, 1);
      check("push_count", push_cnt, exp_pushes);
      check("bursts_left", eb_addr_q.size(), 0);
      check("beats_left", exp_q.size(), 0);
      step(1'b0);
      check("idle_busy", busy_o, 0);
      check("idle_arvalid", arvalid_o, 0);
   endtask

   task automatic run_frame(input logic [31:0] s, input logic [31:0] sz, input logic [7:0] bl);
      start_frame(s, sz, bl);
      finish_frame(int'(sz >> 2));
   endtask

   task automatic wait_burst();
      int budget;
      budget = 0;
      while (sl_left == 0 && budget < 50) begin
         step(1'b0);
         budget++;
      end
      check("burst_started", (sl_left > 0) ? 1 : 0, 1);
   endtask

   initial begin
      logic [31:0] s, sz;
      logic [7:0]  bl;
      int budget;
      rst_i = 1'b1; en_i = 1'b0; frame_start_i = 1'b0; arready_i = 1'b0; rlast_i = 1'b0;
      rvalid_i = 1'b0; err_clr_i = 1'b0; fbstart_i = '0; fbsize_i = '0; brulen_i = '0;
      fifo_free_i = '0; rdata_i = '0; rresp_i = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_arvalid", arvalid_o, 0);
      check("rst_rready", rready_o, 0);
      check("rst_fifo_wr", fifo_wr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_frame_done", frame_done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_araddr", araddr_o, 0);
      check("rst_arlen", arlen_o, 0);

      // Basic two-burst frame, 4 KB split, tail and edge configurations.
      run_frame(32'h1000, 32'd64, 8'd8);
      run_frame(32'h0FF0, 32'd64, 8'd16);
      run_frame(32'h2004, 32'd20, 8'd8);
      run_frame(32'h3000, 32'd12, 8'd0);
      run_frame(32'h4000, 32'd0, 8'd8);
      check("zero_no_ar", arvalid_o, 0);

      // Back-pressure: stall in WAIT_SPACE, then AR held against arready=0.
      free_fixed = 10'd5;
      start_frame(32'h2000, 32'd32, 8'd8);
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         check("bp_stall_arvalid", arvalid_o, 0);
         check("bp_stall_busy", busy_o, 1);
      end
      free_fixed = 10'd8;
      ar_block   = 1'b1;
      step(1'b0);
      step(1'b0);
      check("bp_arvalid_rise", arvalid_o, 1);
      for (int i = 0; i < 4; i++) step(1'b0);
      ar_block   = 1'b0;
      free_fixed = 10'd512;
      finish_frame(8);

      // Late frame during DATA: current burst ends, then the new frame runs.
      start_frame(32'h3000, 32'd64, 8'd4);
      wait_burst();
      fbstart_i = 32'h5000;
      fbsize_i  = 32'd32;
      while (exp_q.size() > sl_left) void'(exp_q.pop_back());
      eb_addr_q.delete();
      eb_len_q.delete();
      build_frame(32'h5000, 32'd32, 8'd4);
      step(1'b1);
      err_m = 1'b1;
      finish_frame(12);
      clr_v = 1'b1;
      step(1'b0);
      clr_v = 1'b0;
      step(1'b0);

      // Error response on one beat: still pushed, error flagged.
      start_frame(32'h7000, 32'd16, 8'd4);
      wait_burst();
      bad_resp_v = 1'b1;
      step(1'b0);
      bad_resp_v = 1'b0;
      finish_frame(4);
      clr_v = 1'b1;
      step(1'b0);
      clr_v = 1'b0;

      // Enable dropped while AR is pending: burst completes, then idle.
      ar_block = 1'b1;
      start_frame(32'h6000, 32'd64, 8'd8);
      budget = 0;
      while (!arvalid_o && budget < 10) begin
         step(1'b0);
         budget++;
      end
      check("en_ar_seen", arvalid_o, 1);
      en_v = 1'b0;
      step(1'b0);
      step(1'b0);
      while (eb_addr_q.size() > 1) void'(eb_addr_q.pop_back());
      while (eb_len_q.size() > 1) void'(eb_len_q.pop_back());
      while (exp_q.size() > 8) void'(exp_q.pop_back());
      ar_block = 1'b0;
      budget   = 0;
      while ((busy_o || sl_left > 0) && budget < 100) begin
         step(1'b0);
         budget++;
      end
      check("en_idle_busy", busy_o, 0);
      check("en_no_done", done_cnt, 0);
      check("en_beats_left", exp_q.size(), 0);
      check("en_bursts_left", eb_addr_q.size(), 0);
      en_v = 1'b1;

      // Randomised frames with random handshakes and FIFO space.
      hs_rand   = 1'b1;
      free_rand = 1'b1;
      for (int n = 0; n < 20; n++) begin
         s  = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 1023)) << 2)
              | 32'($urandom_range(0, 3));
         sz = 32'($urandom_range(0, 1200));
         bl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16));
         run_frame(s, sz, bl);
      end
      hs_rand   = 1'b0;
      free_rand = 1'b0;

      // Reset in the middle of a burst, with the error flag set.
      start_frame(32'h8000, 32'd64, 8'd8);
      wait_burst();
      step(1'b1);
      err_m = 1'b1;
      rst_v = 1'b1;
      step(1'b0);
      rst_v = 1'b0;
      exp_q.delete();
      eb_addr_q.delete();
      eb_len_q.delete();
      step(1'b0);
      check("mid_rst_arvalid", arvalid_o, 0);
      check("mid_rst_rready", rready_o, 0);
      check("mid_rst_fifo_wr", fifo_wr_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_frame_done", frame_done_o, 0);
      check("mid_rst_err", err_o, 0);
      check("mid_rst_araddr", araddr_o, 0);
      check("mid_rst_arlen", arlen_o, 0);
      run_frame(32'h9000, 32'd40, 8'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/vga_fb_fetch_ctrl.md
Name: vga_fb_fetch_ctrl

Overview:
- Sequences framebuffer reads for the VGA controller. On each frame-start it issues AXI4 INCR read bursts covering [FBSTART, FBSTART+FBSIZE) and pushes returned beats into the pixel FIFO.
- Handles burst clipping to the configured burst length, remaining frame data and 4 KB boundaries.
- Provides FIFO back-pressure, restart on late frames, and error flagging.
- Sits between the APB4 register bank (config source), the AXI4 read channels, and the pixel FIFO that feeds the timing/RGB datapath.

Parameters:
ADDR_WIDTH, 32, AXI address and FBSTART/FBSIZE width
DATA_WIDTH, 32, AXI read data width; fixed 4 bytes per beat
FIFO_CNT_WIDTH, 10, width of the FIFO free-entry count

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  global enable (CTRL.EN)
fbstart_i  in  ADDR_WIDTH  framebuffer byte base; bits[1:0] ignored
fbsize_i  in  ADDR_WIDTH  framebuffer size in bytes; bits[1:0] ignored
brulen_i  in  8  max beats per burst; 0 treated as 1
frame_start_i  in  1  one-cycle pulse at frame start (from vsync)
fifo_free_i  in  FIFO_CNT_WIDTH  free FIFO entries
fifo_wr_o  out  1  FIFO push strobe
fifo_wdata_o  out  DATA_WIDTH  FIFO push data (= rdata_i)
araddr_o  out  ADDR_WIDTH  AXI read address
arlen_o  out  8  AXI burst length minus 1
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
rdata_i  in  DATA_WIDTH  AXI read data
rresp_i  in  2  AXI read response
rlast_i  in  1  AXI last beat
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
busy_o  out  1  frame fetch in progress (state != IDLE)
frame_done_o  out  1  one-cycle pulse when the last beat of a frame is pushed
err_o  out  1  sticky error
err_clr_i  in  1  clears err_o

Behaviour:
- Reset: state IDLE. All outputs 0: arvalid_o, rready_o, fifo_wr_o, busy_o, frame_done_o, err_o, araddr_o, arlen_o. Internal address, remaining-beat count and pending flag are cleared.
- Config is latched on an accepted frame_start_i: addr = {fbstart_i[AW-1:2],2'b00}, remaining beats = fbsize_i>>2. Mid-frame register writes do not affect the frame in flight.
- Burst beats: B = min(max(brulen_i,1), remaining, (4096 - addr[11:0])>>2). B is computed in WAIT_SPACE and registered into arlen_o = B-1. B is always ≥1 and ≤256.
- FSM states:
  - IDLE: frame_start_i & en_i → latch config. If remaining==0, pulse frame_done_o next cycle and stay IDLE; otherwise go to WAIT_SPACE. frame_start_i with en_i=0 is ignored.
  - WAIT_SPACE: when fifo_free_i ≥ B, register araddr_o/arlen_o and assert arvalid_o next cycle → ADDR.
  - ADDR: arvalid_o=1; araddr_o/arlen_o held stable until arready_i. The handshake cycle → DATA; addr += B*4; remaining -= B.
  - DATA: rready_o=1. Every cycle with rvalid_i, fifo_wr_o=1 and fifo_wdata_o=rdata_i (combinational, zero latency). On a beat with rlast_i:
    - if a restart is pending → latch new config → WAIT_SPACE;
    - else if en_i=0 → IDLE;
    - else if remaining==0 → frame_done_o pulse (same cycle as the last push) → IDLE;
    - else → WAIT_SPACE.
- One outstanding burst at a time. Only rlast_i ends DATA. If the beat count at rlast_i differs from B, set err_o; the counters are not corrected.
- Any beat with rresp_i != 0 sets err_o; data is still pushed.
- Late frame: frame_start_i while busy_o=1 sets err_o and the pending-restart flag. The in-flight burst always completes (no AXI abort). From WAIT_SPACE, the restart takes effect immediately in the next cycle.
- en_i deassert: in-flight AR/R transactions complete, then IDLE. In WAIT_SPACE, go to IDLE next cycle.
- err_clr_i clears err_o. A same-cycle set wins.
- Reset asserted mid-burst: immediate return to the reset state. The system resets the AXI slave concurrently.

Test Plan:
1. fbstart=0x1000, fbsize=64, brulen=8, fifo_free=512, arready/rvalid always 1 → two bursts: araddr 0x1000/0x1020, arlen 7/7; 16 fifo_wr_o pulses; frame_done_o coincides with the 16th push.
2. 4 KB crossing: fbstart=0x0FF0, fbsize=64, brulen=16 → bursts (0x0FF0, arlen 3), (0x1000, arlen 11); no burst crosses 0x1000.
3. Back-pressure: fifo_free=5, brulen=8 → stalls in WAIT_SPACE with arvalid_o=0; raising fifo_free to 8 → arvalid_o rises within 1 cycle; arready held low 5 cycles → araddr/arlen stable throughout.
4. Tail and edge configs: fbsize=20, brulen=8 → single burst arlen=4. brulen=0 → arlen=0 bursts. fbsize=0 → frame_done_o pulse, no AR.
5. frame_start_i mid-DATA → err_o=1, current burst completes, next araddr=fbstart; err_clr_i → err_o=0. rresp=2'b10 on one beat → err_o=1, beat still pushed.
6. en_i dropped during ADDR → AR handshake and burst complete, then IDLE with busy_o=0. rst_i mid-DATA → all outputs 0 the next cycle.
